// File: rtl/frame_row_reader.sv
// Read-side sequencer: walks a row span on the frame buffer's registered read port and
// streams rows over valid/ready. Optional READER_CONT_EN restarts the last span from DONE.
module frame_row_reader #(
  parameter int ROW_W    = 640,
  parameter int NUM_ROWS = 480,
  parameter int ADDR_W   = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_row,
  input  logic [ADDR_W-1:0] num_rows,
  input  logic              ram_full,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [ROW_W-1:0]  ram_data,
  output logic [ROW_W-1:0]  row_data,
  output logic [ADDR_W-1:0] row_idx,
  output logic              row_last,
  output logic              row_valid,
  input  logic              row_ready,
  output logic              busy,
  output logic              done,
  output logic              err_range
);

  localparam int QD = 3;
  localparam logic [ADDR_W:0]   NUM_ROWS_W = (ADDR_W+1)'(NUM_ROWS);
  localparam logic [ADDR_W-1:0] ONE_A      = 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [ADDR_W-1:0] left_q, left_d;
  logic [ADDR_W-1:0] last_row_q, last_row_d;
  logic [ADDR_W-1:0] cap_idx_q, cap_idx_d;
  logic              a_q, a_d, b_q, b_d;
  logic              err_q, err_d;
  logic [ROW_W-1:0]  q_data_q [QD];
  logic [ROW_W-1:0]  q_data_d [QD];
  logic [ADDR_W-1:0] q_idx_q [QD];
  logic [ADDR_W-1:0] q_idx_d [QD];
  logic [QD-1:0]     q_last_q, q_last_d;
  logic [1:0]        q_cnt_q, q_cnt_d;
`ifdef READER_CONT_EN
  logic [ADDR_W-1:0] span_first_q, span_first_d;
  logic [ADDR_W-1:0] span_num_q, span_num_d;
`endif

  logic              launch;
  logic [ADDR_W-1:0] launch_first, launch_num;
  logic              xfer, issue, range_bad;
  logic [ADDR_W:0]   span_end;
  logic [2:0]        occ;
  logic [1:0]        wr;

  assign span_end  = {1'b0, first_row} + {1'b0, num_rows};
  assign range_bad = span_end > NUM_ROWS_W;
  assign xfer      = (q_cnt_q != 2'd0) && row_ready;
  // a_q: address on the port, b_q: row on ram_data. Both always land in the queue, so
  // issue only when every outstanding row still fits after this cycle's transfer.
  assign occ       = {1'b0, q_cnt_q} + {2'b00, a_q} + {2'b00, b_q} - {2'b00, xfer};
  assign issue     = (state_q == S_RUN) && (left_q != '0) && (occ <= 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ram_addr_q <= '0;
      left_q     <= '0;
      last_row_q <= '0;
      cap_idx_q  <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      err_q      <= 1'b0;
      q_last_q   <= '0;
      q_cnt_q    <= '0;
      for (int unsigned i = 0; i < QD; i++) begin
        q_data_q[i] <= '0;
        q_idx_q[i]  <= '0;
      end
`ifdef READER_CONT_EN
      span_first_q <= '0;
      span_num_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ram_addr_q <= ram_addr_d;
      left_q     <= left_d;
      last_row_q <= last_row_d;
      cap_idx_q  <= cap_idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      err_q      <= err_d;
      q_last_q   <= q_last_d;
      q_cnt_q    <= q_cnt_d;
      for (int unsigned i = 0; i < QD; i++) begin
        q_data_q[i] <= q_data_d[i];
        q_idx_q[i]  <= q_idx_d[i];
      end
`ifdef READER_CONT_EN
      span_first_q <= span_first_d;
      span_num_q   <= span_num_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    launch       = 1'b0;
    launch_first = first_row;
    launch_num   = num_rows;
    err_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && ram_full) begin
          if (range_bad) err_d  = 1'b1;
          else           launch = 1'b1;
        end
      end
      S_RUN: begin
        if (xfer && q_last_q[0]) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifdef READER_CONT_EN
        if (ram_full) begin
          launch       = 1'b1;
          launch_first = span_first_q;
          launch_num   = span_num_q;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
    if (launch) state_d = (launch_num == '0) ? S_DONE : S_RUN;
  end

  always_comb begin
    ram_addr_d = ram_addr_q;
    left_d     = left_q;
    last_row_d = last_row_q;
    cap_idx_d  = cap_idx_q;
    a_d        = 1'b0;
    b_d        = a_q;
`ifdef READER_CONT_EN
    span_first_d = launch ? launch_first : span_first_q;
    span_num_d   = launch ? launch_num   : span_num_q;
`endif
    if (launch && (launch_num != '0)) begin
      ram_addr_d = launch_first;
      left_d     = launch_num - ONE_A;
      last_row_d = launch_first + launch_num - ONE_A;
      cap_idx_d  = launch_first;
      a_d        = 1'b1;
    end else if (issue) begin
      ram_addr_d = ram_addr_q + ONE_A;
      left_d     = left_q - ONE_A;
      a_d        = 1'b1;
    end
    if (b_q) cap_idx_d = cap_idx_q + ONE_A;

    q_data_d = q_data_q;
    q_idx_d  = q_idx_q;
    q_last_d = q_last_q;
    wr       = q_cnt_q;
    if (xfer) begin
      for (int unsigned i = 0; i < QD - 1; i++) begin
        q_data_d[i] = q_data_q[i+1];
        q_idx_d[i]  = q_idx_q[i+1];
        q_last_d[i] = q_last_q[i+1];
      end
      wr = q_cnt_q - 2'd1;
    end
    if (b_q) begin
      q_data_d[wr] = ram_data;
      q_idx_d[wr]  = cap_idx_q;
      q_last_d[wr] = (cap_idx_q == last_row_q);
    end
    q_cnt_d = wr + {1'b0, b_q};
  end

  always_comb begin
    ram_addr  = ram_addr_q;
    row_data  = q_data_q[0];
    row_idx   = q_idx_q[0];
    row_last  = q_last_q[0];
    row_valid = (q_cnt_q != 2'd0);
    busy      = (state_q == S_RUN);
    done      = (state_q == S_DONE);
    err_range = err_q;
  end

endmodule

// File: tb/tb_frame_row_reader.sv
// Self-checking bench for frame_row_reader: directed spans plus randomized spans and
// backpressure, checked against a queue-of-row-indices reference model.
module tb_frame_row_reader;
  localparam int ROW_W    = 640;
  localparam int NUM_ROWS = 480;
  localparam int ADDR_W   = 9;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] first_row = '0;
  logic [ADDR_W-1:0] num_rows = '0;
  logic              ram_full = 1'b0;
  logic [ADDR_W-1:0] ram_addr;
  logic [ROW_W-1:0]  ram_data;
  logic [ROW_W-1:0]  row_data;
  logic [ADDR_W-1:0] row_idx;
  logic              row_last, row_valid, busy, done, err_range;
  logic              row_ready = 1'b0;

  logic [ROW_W-1:0]  mem [NUM_ROWS];
  int                checks = 0;
  int                errors = 0;
  int                exp_q[$];
  int                span_first = 0;
  int                span_last = 0;
  bit                held = 0;
  logic [ADDR_W-1:0] h_idx;
  logic [ROW_W-1:0]  h_data;
  bit                prev_busy = 0;
  logic [ADDR_W-1:0] prev_addr;

  frame_row_reader #(.ROW_W(ROW_W), .NUM_ROWS(NUM_ROWS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .first_row(first_row), .num_rows(num_rows),
    .ram_full(ram_full), .ram_addr(ram_addr), .ram_data(ram_data), .row_data(row_data),
    .row_idx(row_idx), .row_last(row_last), .row_valid(row_valid), .row_ready(row_ready),
    .busy(busy), .done(done), .err_range(err_range)
  );

  always #5 clk = ~clk;

  // Frame buffer: address registered at the edge, row available for the following cycle.
  always @(posedge clk) ram_data <= (ram_addr < NUM_ROWS) ? mem[ram_addr] : '0;

  task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    int e;
    if (rst) begin
      held = 0;
      prev_busy = 0;
    end else begin
      if (row_valid && row_ready) begin
        chk("row_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("row_idx", row_idx, e);
          chk("row_data", row_data, mem[e]);
          chk("row_last", row_last, e == span_last);
        end
      end
      if (held) begin
        chk("hold_valid", row_valid, 1'b1);
        chk("hold_idx", row_idx, h_idx);
        chk("hold_data", row_data, h_data);
      end
      held   = row_valid && !row_ready;
      h_idx  = row_idx;
      h_data = row_data;
      if (busy) begin
        chk("addr_range", (ram_addr >= span_first) && (ram_addr <= span_last), 1'b1);
        if (prev_busy) chk("addr_step", (ram_addr == prev_addr) || (ram_addr == prev_addr + 1), 1'b1);
      end
      prev_busy = busy;
      prev_addr = ram_addr;
    end
  endtask

  task automatic cycle(input logic rdy);
    row_ready = rdy;
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic push_span(input int f, input int n);
    span_first = f;
    span_last  = f + n - 1;
    for (int i = 0; i < n; i++) exp_q.push_back(f + i);
  endtask

  task automatic do_start(input int f, input int n, input logic full);
    first_row = ADDR_W'(f);
    num_rows  = ADDR_W'(n);
    ram_full  = full;
    start     = 1'b1;
    cycle(1'b1);
    start     = 1'b0;
  endtask

  // mode 0: ready held, 1: pattern 1,0,0,1, 2: random
  task automatic run_span(input int budget, input int mode);
    bit   got = 0;
    int   err_seen = 0;
    logic r;
    for (int i = 0; i < budget && !got; i++) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = ((i % 4) == 0) || ((i % 4) == 3);
        default: r = ($urandom_range(0, 99) < 60);
      endcase
      start     = (i == 2);
      first_row = ADDR_W'($urandom_range(0, 511));
      num_rows  = ADDR_W'($urandom_range(0, 511));
      cycle(r);
      start = 1'b0;
      if (err_range) err_seen++;
      if (done) got = 1;
    end
    chk("span_done", got, 1'b1);
    chk("model_drained", exp_q.size(), 0);
    chk("no_err_in_span", err_seen, 0);
    cycle(1'b1);
    chk("done_one_cycle", done, 1'b0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_data"}, row_data, 0);
    chk({tag, "_idx"}, row_idx, 0);
    chk({tag, "_last"}, row_last, 0);
    chk({tag, "_valid"}, row_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err_range, 0);
  endtask

  initial begin
    logic [31:0] w;
    int f, n;
    for (int r = 0; r < NUM_ROWS; r++)
      for (int k = 0; k < ROW_W / 32; k++) begin
        w = $urandom;
        mem[r][k*32 +: 32] = w;
      end

    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b0);
    cycle(1'b0);
    chk_reset("reset");
    rst = 1'b0;
    cycle(1'b0);

`ifdef READER_CONT_EN
    push_span(0, 4);
    do_start(0, 4, 1'b1);
    for (int s = 0; s < 3; s++) begin
      run_span(40, 0);
      chk("cont_restart_busy", busy, 1'b1);
      push_span(0, 4);
    end
    rst = 1'b1;
    cycle(1'b1);
    rst = 1'b0;
    exp_q.delete();
    chk_reset("cont_rst");
`else
    // full frame, no backpressure
    push_span(0, 480);
    do_start(0, 480, 1'b1);
    chk("t1_addr0", ram_addr, 0);
    chk("t1_busy", busy, 1'b1);
    chk("t1_nv_e0", row_valid, 1'b0);
    cycle(1'b1);
    chk("t1_nv_e1", row_valid, 1'b0);
    cycle(1'b1);
    chk("t1_valid_e2", row_valid, 1'b1);
    for (int i = 0; i < 480; i++) begin
      chk("t1_stream", row_valid, 1'b1);
      cycle(1'b1);
    end
    chk("t1_done", done, 1'b1);
    chk("t1_busy_off", busy, 1'b0);
    chk("t1_drained", exp_q.size(), 0);
    cycle(1'b1);
    chk("t1_done_off", done, 1'b0);

    // backpressured short span
    push_span(10, 4);
    do_start(10, 4, 1'b1);
    run_span(60, 1);

    // range boundary: reject one past the end, accept exactly to the end
    do_start(470, 11, 1'b1);
    chk("t3_err", err_range, 1'b1);
    chk("t3_busy", busy, 1'b0);
    cycle(1'b1);
    chk("t3_err_off", err_range, 1'b0);
    chk("t3_busy2", busy, 1'b0);
    chk("t3_novalid", row_valid, 1'b0);
    push_span(470, 10);
    do_start(470, 10, 1'b1);
    run_span(80, 2);

    // not full, and empty span
    do_start(5, 3, 1'b0);
    chk("t4_busy", busy, 1'b0);
    chk("t4_err", err_range, 1'b0);
    chk("t4_done", done, 1'b0);
    cycle(1'b1);
    chk("t4_novalid", row_valid, 1'b0);
    do_start(5, 0, 1'b1);
    chk("t4_zero_done", done, 1'b1);
    chk("t4_zero_busy", busy, 1'b0);
    chk("t4_zero_valid", row_valid, 1'b0);
    cycle(1'b1);
    chk("t4_zero_done_off", done, 1'b0);

    // reset mid-span, then restart
    push_span(0, 20);
    do_start(0, 20, 1'b1);
    for (int i = 0; i < 40 && exp_q.size() > 14; i++) cycle(1'b1);
    chk("t5_reached_row5", exp_q.size(), 14);
    rst = 1'b1;
    cycle(1'b1);
    rst = 1'b0;
    exp_q.delete();
    chk_reset("t5_rst");
    push_span(0, 3);
    do_start(0, 3, 1'b1);
    run_span(30, 0);

    // randomized accepted and rejected spans
    for (int k = 0; k < 8; k++) begin
      f = $urandom_range(0, 479);
      n = $urandom_range(1, (480 - f) < 24 ? (480 - f) : 24);
      push_span(f, n);
      do_start(f, n, 1'b1);
      run_span(200, 2);
      f = $urandom_range(400, 479);
      n = $urandom_range(481 - f, 200);
      do_start(f, n, 1'b1);
      chk("rand_err", err_range, 1'b1);
      chk("rand_err_busy", busy, 1'b0);
      cycle(1'b1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
